// File: rtl/pf_out_pkg.sv
// -----------------------------------------------------------------------------
// pf_out_pkg
// Shared definitions for the pf_out_ser_bank differential serialiser bank:
//   - state_e      : bank FSM states (IDLE, SHIFT)
//   - *_MIN/*_MAX  : legal ranges for the CHANNELS and SER_W parameters
//   - calc_cnt_w() : width of the per-word bit counter for a given SER_W
// -----------------------------------------------------------------------------
package pf_out_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int unsigned CHANNELS_MIN = 32'd1;
  localparam int unsigned CHANNELS_MAX = 32'd16;
  localparam int unsigned SER_W_MIN    = 32'd2;
  localparam int unsigned SER_W_MAX    = 32'd32;

  // Counter width CNT_W = $clog2(SER_W), never narrower than one bit.
  function automatic int unsigned calc_cnt_w(input int unsigned ser_w);
    int unsigned w;
    w = $clog2(ser_w);
    if (w < 32'd1) begin
      w = 32'd1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/pf_out_ser_lane.sv
// -----------------------------------------------------------------------------
// pf_out_ser_lane
// One differential lane of the serialiser bank. Holds the lane shift register,
// the per-word enable latch and the registered pad driver.
// Ports:
//   i_clk, i_reset   clock and synchronous active-high reset
//   i_load           load i_word / latch i_ch_en on this edge (word boundary)
//   i_advance        shift to the next bit on this edge
//   i_active         bank will be in SHIFT after this edge
//   i_word           parallel word for this lane
//   i_ch_en          lane enable, captured only at a load
//   i_invert         live polarity swap
//   o_padop/o_padon  complementary pad outputs (registered)
// -----------------------------------------------------------------------------
module pf_out_ser_lane
  import pf_out_pkg::*;
#(
  parameter int unsigned SER_W      = 32'd8,
  parameter bit          IDLE_LEVEL = 1'b0,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic             i_advance,
  input  logic             i_active,
  input  logic [SER_W-1:0] i_word,
  input  logic             i_ch_en,
  input  logic             i_invert,
  output logic             o_padop,
  output logic             o_padon
);

  logic [SER_W-1:0] r_shreg;
  logic             r_en;
  logic             r_out;

  logic [SER_W-1:0] w_shreg_nxt;
  logic             w_en_nxt;
  logic             w_bit;
  logic             w_out_nxt;

  // Next shift-register contents, enable and pad level. The pad flop is fed
  // from the post-edge shift register so the first bit of a freshly loaded
  // word reaches the pad on the same edge that loads it.
  always_comb begin
    w_shreg_nxt = r_shreg;
    w_en_nxt    = r_en;
    w_bit       = 1'b0;
    w_out_nxt   = IDLE_LEVEL ^ i_invert;

    if (i_load) begin
      w_shreg_nxt = i_word;
      w_en_nxt    = i_ch_en;
    end else if (i_advance) begin
      if (MSB_FIRST) begin
        w_shreg_nxt = {r_shreg[SER_W-2:0], 1'b0};
      end else begin
        w_shreg_nxt = {1'b0, r_shreg[SER_W-1:1]};
      end
    end else begin
      w_shreg_nxt = r_shreg;
    end

    if (MSB_FIRST) begin
      w_bit = w_shreg_nxt[SER_W-1];
    end else begin
      w_bit = w_shreg_nxt[0];
    end

    if (i_active && w_en_nxt) begin
      w_out_nxt = w_bit ^ i_invert;
    end else begin
      w_out_nxt = IDLE_LEVEL ^ i_invert;
    end
  end

  // Lane state registers; reset drives the raw idle level, ignoring i_invert.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shreg <= {SER_W{1'b0}};
      r_en    <= 1'b0;
      r_out   <= IDLE_LEVEL;
    end else begin
      r_shreg <= w_shreg_nxt;
      r_en    <= w_en_nxt;
      r_out   <= w_out_nxt;
    end
  end

  assign o_padop = r_out;
  assign o_padon = ~r_out;

endmodule

// File: rtl/pf_out_ser_bank.sv
// -----------------------------------------------------------------------------
// pf_out_ser_bank
// Multi-channel differential output serialiser. Accepts one parallel word per
// lane through a valid/ready handshake and shifts it out one bit per cycle on
// CHANNELS complementary pad pairs, with a one-word holding register so that
// consecutive words stream with no idle bit between them.
// Ports:
//   i_clk, i_reset   clock and synchronous active-high reset
//   i_data           lane k word at [k*SER_W +: SER_W]
//   i_data_valid     i_data holds a word
//   o_data_ready     bank accepts a word this cycle
//   i_ch_en          per-lane enable, captured at each word load
//   i_invert         per-lane polarity swap, applied live
//   o_busy           a word is being shifted
//   o_stream_end     one-cycle pulse in the first idle cycle after a stream
//   o_padop/o_padon  positive/negative pads (o_padon == ~o_padop)
// -----------------------------------------------------------------------------
module pf_out_ser_bank
  import pf_out_pkg::*;
#(
  parameter int unsigned CHANNELS   = 32'd4,
  parameter int unsigned SER_W      = 32'd8,
  parameter bit          IDLE_LEVEL = 1'b0,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [CHANNELS*SER_W-1:0] i_data,
  input  logic                      i_data_valid,
  output logic                      o_data_ready,
  input  logic [CHANNELS-1:0]       i_ch_en,
  input  logic [CHANNELS-1:0]       i_invert,
  output logic                      o_busy,
  output logic                      o_stream_end,
  output logic [CHANNELS-1:0]       o_padop,
  output logic [CHANNELS-1:0]       o_padon
);

  localparam int unsigned      CNT_W    = calc_cnt_w(SER_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SER_W - 32'd1);

  // Out-of-range parameters stop elaboration.
  if ((CHANNELS < CHANNELS_MIN) || (CHANNELS > CHANNELS_MAX) ||
      (SER_W < SER_W_MIN) || (SER_W > SER_W_MAX)) begin : g_param_check
    $error("pf_out_ser_bank: CHANNELS or SER_W out of range");
  end

  state_e                     r_state;
  logic [CNT_W-1:0]           r_cnt;
  logic [CHANNELS*SER_W-1:0]  r_hold;
  logic                       r_hold_full;
  logic                       r_stream_end;

  state_e                     w_state_nxt;
  logic [CNT_W-1:0]           w_cnt_nxt;
  logic [CHANNELS*SER_W-1:0]  w_hold_nxt;
  logic                       w_hold_full_nxt;
  logic                       w_stream_end_nxt;
  logic                       w_xfer;
  logic                       w_load;
  logic                       w_advance;
  logic                       w_active;
  logic [CHANNELS*SER_W-1:0]  w_load_word;

  assign o_data_ready = !r_hold_full && !i_reset;
  assign w_xfer       = i_data_valid && o_data_ready;
  assign w_active     = (w_state_nxt == SHIFT);

  // FSM next state, bit counter, holding register and lane load control.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_hold_nxt       = r_hold;
    w_hold_full_nxt  = r_hold_full;
    w_stream_end_nxt = 1'b0;
    w_load           = 1'b0;
    w_advance        = 1'b0;
    w_load_word      = i_data;

    case (r_state)
      IDLE: begin
        w_cnt_nxt = {CNT_W{1'b0}};
        if (w_xfer) begin
          w_load      = 1'b1;
          w_state_nxt = SHIFT;
        end else begin
          w_state_nxt = IDLE;
        end
      end

      SHIFT: begin
        if (r_cnt != CNT_LAST) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          w_advance = 1'b1;
          if (w_xfer) begin
            w_hold_nxt      = i_data;
            w_hold_full_nxt = 1'b1;
          end else begin
            w_hold_full_nxt = r_hold_full;
          end
        end else begin
          // Last bit of the current word: chain the next word in without a gap.
          w_cnt_nxt = {CNT_W{1'b0}};
          if (r_hold_full) begin
            w_load      = 1'b1;
            w_load_word = r_hold;
            if (w_xfer) begin
              w_hold_nxt      = i_data;
              w_hold_full_nxt = 1'b1;
            end else begin
              w_hold_full_nxt = 1'b0;
            end
          end else if (w_xfer) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt      = IDLE;
            w_stream_end_nxt = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Control registers; reset discards any word in flight without a stream-end pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_cnt        <= {CNT_W{1'b0}};
      r_hold       <= {(CHANNELS*SER_W){1'b0}};
      r_hold_full  <= 1'b0;
      r_stream_end <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_hold       <= w_hold_nxt;
      r_hold_full  <= w_hold_full_nxt;
      r_stream_end <= w_stream_end_nxt;
    end
  end

  assign o_busy       = (r_state == SHIFT);
  assign o_stream_end = r_stream_end;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    pf_out_ser_lane #(
      .SER_W      (SER_W),
      .IDLE_LEVEL (IDLE_LEVEL),
      .MSB_FIRST  (MSB_FIRST)
    ) u_lane (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_load    (w_load),
      .i_advance (w_advance),
      .i_active  (w_active),
      .i_word    (w_load_word[k*SER_W +: SER_W]),
      .i_ch_en   (i_ch_en[k]),
      .i_invert  (i_invert[k]),
      .o_padop   (o_padop[k]),
      .o_padon   (o_padon[k])
    );
  end

endmodule

// File: tb/tb_pf_out_ser_bank.sv
`timescale 1ns/1ps
module tb_pf_out_ser_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data;
  logic        valid;
  logic        rdy;
  logic [3:0]  ch_en;
  logic [3:0]  inv;
  logic        busy;
  logic        se;
  logic [3:0]  pp;
  logic [3:0]  pn;
  logic [10:0] obs;

  int total = 0;
  int bad   = 0;

  // Scoreboard of expected per-cycle frames {padop, padon, busy, stream_end, ready}.
  logic [10:0] q[$];

  always #5 clk = ~clk;

  pf_out_ser_bank #(
    .CHANNELS   (32'd4),
    .SER_W      (32'd8),
    .IDLE_LEVEL (1'b0),
    .MSB_FIRST  (1'b1)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_data       (data),
    .i_data_valid (valid),
    .o_data_ready (rdy),
    .i_ch_en      (ch_en),
    .i_invert     (inv),
    .o_busy       (busy),
    .o_stream_end (se),
    .o_padop      (pp),
    .o_padon      (pn)
  );

  assign obs = {pp, pn, busy, se, rdy};

  function automatic logic [10:0] mk(input logic [3:0] p, input logic b, input logic s, input logic r);
    return {p, ~p, b, s, r};
  endfunction

  // Expected pad levels while bit i (0 = first sent, MSB first) of word w is out.
  function automatic logic [3:0] word_pads(input logic [31:0] w, input int i,
                                           input logic [3:0] en, input logic [3:0] iv);
    logic [3:0] r;
    for (int k = 0; k < 4; k++) begin
      r[k] = en[k] ? (w[k*8 + 7 - i] ^ iv[k]) : iv[k];
    end
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; data = 32'h0; ch_en = 4'h0; inv = 4'hF;
    repeat (3) @(negedge clk);
    total++;
    if (obs !== mk(4'h0, 1'b0, 1'b0, 1'b0)) begin
      bad++; $display("FAIL reset_hold: got %b expected %b", obs, mk(4'h0, 1'b0, 1'b0, 1'b0));
    end
    inv = 4'h0; rst = 1'b0;
    for (int j = 1; j <= 2; j++) begin
      @(negedge clk);
      total++;
      if (obs !== mk(4'h0, 1'b0, 1'b0, 1'b1)) begin
        bad++; $display("FAIL reset_release cycle %0d: got %b expected %b", j, obs, mk(4'h0, 1'b0, 1'b0, 1'b1));
      end
    end
  endtask

  task automatic test_single_word();
    logic [31:0] w;
    logic [10:0] e;
    int n;
    w = 32'h810F3CA5;
    data = w; valid = 1'b1; ch_en = 4'hF; inv = 4'h0;
    for (int i = 0; i < 8; i++) q.push_back(mk(word_pads(w, i, 4'hF, 4'h0), 1'b1, 1'b0, 1'b1));
    q.push_back(mk(4'h0, 1'b0, 1'b1, 1'b1));
    q.push_back(mk(4'h0, 1'b0, 1'b0, 1'b1));
    total++;
    if (rdy !== 1'b1) begin bad++; $display("FAIL single_ready: got %b expected 1", rdy); end
    n = q.size();
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      e = q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL single frame %0d: got %b expected %b", j, obs, e); end
      if (j == 1) valid = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w[3];
    logic [10:0] e;
    int n;
    int jj;
    w[0] = 32'hA55AC33C; w[1] = 32'h0FF09669; w[2] = 32'h12345678;
    data = w[0]; valid = 1'b1; ch_en = 4'hF; inv = 4'h0;
    for (int m = 0; m < 3; m++) begin
      for (int i = 0; i < 8; i++) begin
        jj = m * 8 + i + 1;
        q.push_back(mk(word_pads(w[m], i, 4'hF, 4'h0), 1'b1, 1'b0,
                       (jj == 1 || jj == 9 || jj >= 17) ? 1'b1 : 1'b0));
      end
    end
    q.push_back(mk(4'h0, 1'b0, 1'b1, 1'b1));
    q.push_back(mk(4'h0, 1'b0, 1'b0, 1'b1));
    n = q.size();
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      e = q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL stream frame %0d: got %b expected %b", j, obs, e); end
      if (j == 1) data = w[1];
      if (j == 9) data = w[2];
      if (j == 17) valid = 1'b0;
    end
  endtask

  task automatic test_ch_en();
    logic [31:0] w0, w1;
    logic [10:0] e;
    int n;
    w0 = 32'hF0E1D2C3; w1 = 32'h5AA53CC3;
    data = w0; valid = 1'b1; ch_en = 4'b0101; inv = 4'h0;
    for (int i = 0; i < 8; i++) q.push_back(mk(word_pads(w0, i, 4'b0101, 4'h0), 1'b1, 1'b0, (i == 0) ? 1'b1 : 1'b0));
    for (int i = 0; i < 8; i++) q.push_back(mk(word_pads(w1, i, 4'hF, 4'h0), 1'b1, 1'b0, 1'b1));
    q.push_back(mk(4'h0, 1'b0, 1'b1, 1'b1));
    q.push_back(mk(4'h0, 1'b0, 1'b0, 1'b1));
    n = q.size();
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      e = q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL ch_en frame %0d: got %b expected %b", j, obs, e); end
      if (j == 1) data = w1;
      if (j == 2) valid = 1'b0;
      if (j == 3) ch_en = 4'hF;
    end
  endtask

  task automatic test_invert();
    logic [31:0] w;
    logic [10:0] e;
    int n;
    w = 32'hFFFFFFFF;
    data = w; valid = 1'b1; ch_en = 4'hF; inv = 4'h0;
    for (int i = 0; i < 8; i++) q.push_back(mk(word_pads(w, i, 4'hF, (i >= 3) ? 4'h4 : 4'h0), 1'b1, 1'b0, 1'b1));
    q.push_back(mk(4'h4, 1'b0, 1'b1, 1'b1));
    q.push_back(mk(4'h4, 1'b0, 1'b0, 1'b1));
    n = q.size();
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      e = q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL invert frame %0d: got %b expected %b", j, obs, e); end
      if (j == 1) valid = 1'b0;
      if (j == 3) inv = 4'h4;
    end
    inv = 4'h0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] w0, w1;
    logic [10:0] e;
    int n;
    w0 = 32'h9669A55A; w1 = 32'hFFFFFFFF;
    data = w0; valid = 1'b1; ch_en = 4'hF; inv = 4'h0;
    for (int i = 0; i < 4; i++) q.push_back(mk(word_pads(w0, i, 4'hF, 4'h0), 1'b1, 1'b0, (i == 0) ? 1'b1 : 1'b0));
    q.push_back(mk(4'h0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 12; i++) q.push_back(mk(4'h0, 1'b0, 1'b0, 1'b1));
    n = q.size();
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      e = q.pop_front();
      total++;
      if (obs !== e) begin bad++; $display("FAIL reset_mid frame %0d: got %b expected %b", j, obs, e); end
      if (j == 1) data = w1;
      if (j == 2) valid = 1'b0;
      if (j == 4) rst = 1'b1;
      if (j == 5) rst = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_ch_en();
    test_invert();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
